// File: rtl/motor_sched_pkg.sv
// Shared types for the motor start sequencer: FSM state codes, channel status
// and the index width used by the round-robin arithmetic.
package motor_sched_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StFpulse = 3'd1;
    localparam state_t StS0     = 3'd2;
    localparam state_t StS1     = 3'd3;
    localparam state_t StS10    = 3'd4;
    localparam state_t StGwin   = 3'd5;
    localparam state_t StRetry  = 3'd6;

    typedef enum logic [1:0] {
        ChIdle,
        ChOk,
        ChFail
    } ch_status_t;

    localparam int unsigned MaxCh  = 8;
    localparam int unsigned MaxIdW = $clog2(MaxCh);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping at NUM_CH.
module rr_arbiter
    import motor_sched_pkg::*;
#(
    parameter int unsigned NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req_i,
    input  logic [$clog2(NUM_CH)-1:0] ptr_i,
    output logic [NUM_CH-1:0]         gnt_o,
    output logic [$clog2(NUM_CH)-1:0] idx_o,
    output logic                      valid_o
);

    localparam int unsigned IdW  = $clog2(NUM_CH);
    // One spare bit so ptr + offset cannot overflow before the wrap.
    localparam int unsigned PosW = MaxIdW + 1;

    logic [PosW-1:0] pos;
    logic [IdW-1:0]  sel;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = '0;
        sel     = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            pos = PosW'(ptr_i) + PosW'(k);
            if (pos >= PosW'(NUM_CH)) begin
                pos = pos - PosW'(NUM_CH);
            end
            sel = IdW'(pos);
            if (!valid_o && req_i[sel]) begin
                valid_o    = 1'b1;
                idx_o      = sel;
                gnt_o[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/motor_start_sched.sv
// Shared start-up sequencer: arbitrates motor channels round-robin and runs
// the f pulse / x 1,0,1 detect / g window / y confirm protocol with retries.
module motor_start_sched
    import motor_sched_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned X_TIMEOUT = 16,
    parameter int unsigned Y_WINDOW  = 2,
    parameter int unsigned MAX_RETRY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH-1:0]         x,
    input  logic [NUM_CH-1:0]         y,
    output logic [NUM_CH-1:0]         f,
    output logic [NUM_CH-1:0]         g,
    output logic [NUM_CH-1:0]         done,
    output logic [NUM_CH-1:0]         fail,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] grant_id
);

    localparam int unsigned IdW = $clog2(NUM_CH);
    localparam int unsigned TW  = $clog2(X_TIMEOUT);
    localparam int unsigned WW  = (Y_WINDOW > 1) ? $clog2(Y_WINDOW) : 1;
    localparam int unsigned AW  = 3;

    state_t          state_q, state_d;
    logic [IdW-1:0]  grant_q, grant_d;
    logic [IdW-1:0]  rr_q, rr_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [AW-1:0]   attempt_q, attempt_d;
    logic [NUM_CH-1:0] done_q, done_d;
    ch_status_t      status_q [NUM_CH];
    ch_status_t      status_d [NUM_CH];

    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] arb_gnt;
    logic [IdW-1:0]    arb_idx;
    logic              arb_valid;
    logic [NUM_CH-1:0] grant_oh;
    logic              x_g, y_g;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i] = req[i] && (status_q[i] == ChIdle);
        end
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req_i   (eligible),
        .ptr_i   (rr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign grant_oh = {{(NUM_CH-1){1'b0}}, 1'b1} << grant_q;
    assign x_g      = x[grant_q];
    assign y_g      = y[grant_q];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        tcnt_d    = tcnt_q;
        wcnt_d    = wcnt_q;
        attempt_d = attempt_q;
        done_d    = '0;
        status_d  = status_q;

        // Dropping req releases a finished channel; the granted channel is
        // always ChIdle so this never collides with the FSM updates below.
        for (int i = 0; i < NUM_CH; i++) begin
            if (!req[i] && (status_q[i] != ChIdle)) begin
                status_d[i] = ChIdle;
            end
        end

        if (state_q == StIdle) begin
            if (arb_valid) begin
                grant_d   = arb_idx;
                rr_d      = (arb_idx == IdW'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
                attempt_d = '0;
                state_d   = StFpulse;
            end
        end else if (!req[grant_q]) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StFpulse: begin
                    tcnt_d    = '0;
                    attempt_d = attempt_q + 1'b1;
                    state_d   = StS0;
                end
                StS0, StS1, StS10: begin
                    if ((state_q == StS10) && x_g) begin
                        wcnt_d  = '0;
                        state_d = StGwin;
                    end else if (tcnt_q == TW'(X_TIMEOUT - 1)) begin
                        state_d = StRetry;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                        if (x_g) begin
                            state_d = StS1;
                        end else if (state_q == StS1) begin
                            state_d = StS10;
                        end else begin
                            state_d = StS0;
                        end
                    end
                end
                StGwin: begin
                    if (y_g) begin
                        status_d[grant_q] = ChOk;
                        done_d            = grant_oh;
                        state_d           = StIdle;
                    end else if (wcnt_q == WW'(Y_WINDOW - 1)) begin
                        state_d = StRetry;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                StRetry: begin
                    if (attempt_q <= AW'(MAX_RETRY)) begin
                        state_d = StFpulse;
                    end else begin
                        status_d[grant_q] = ChFail;
                        state_d           = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            rr_q      <= '0;
            tcnt_q    <= '0;
            wcnt_q    <= '0;
            attempt_q <= '0;
            done_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                status_q[i] <= ChIdle;
            end
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            tcnt_q    <= tcnt_d;
            wcnt_q    <= wcnt_d;
            attempt_q <= attempt_d;
            done_q    <= done_d;
            status_q  <= status_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            g[i]    = (status_q[i] == ChOk) || ((state_q == StGwin) && grant_oh[i]);
            fail[i] = (status_q[i] == ChFail);
        end
    end

    assign f        = (state_q == StFpulse) ? grant_oh : '0;
    assign done     = done_q;
    assign busy     = (state_q != StIdle);
    assign grant_id = grant_q;

endmodule
